// File: rtl/msg_register_writer.sv
// Message-stream consumer: decodes header/payload packets and turns payload
// words addressed to MODULE_ID into single-cycle register write strobes.
module msg_register_writer #(
    parameter int MSG_WIDTH         = 32,
    parameter int MSG_LENGTH_WIDTH  = 8,
    parameter int MAX_PACKET_LENGTH = 64,
    parameter int ID_WIDTH          = 8,
    parameter int MODULE_ID         = 1,
    parameter int ADDR_WIDTH        = 7,
    parameter int DATA_WIDTH        = MSG_WIDTH - 1 - ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [MSG_WIDTH-1:0]  in_msg,
    input  logic                  in_msg_nd,
    output logic                  reg_we,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_data,
    output logic                  busy,
    output logic                  error
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] SKIP  = 2'd2;

    localparam logic [MSG_LENGTH_WIDTH-1:0] MAX_LEN =
        MSG_LENGTH_WIDTH'(MAX_PACKET_LENGTH);
    localparam logic [ID_WIDTH-1:0] MY_ID = ID_WIDTH'(MODULE_ID);

    logic [1:0]                  state;
    logic [MSG_LENGTH_WIDTH-1:0] remaining;

    logic                        is_hdr;
    logic [ID_WIDTH-1:0]         hdr_id;
    logic [MSG_LENGTH_WIDTH-1:0] hdr_len;
    logic                        hdr_too_long;
    logic [1:0]                  hdr_next;
    logic                        last_word;

    assign is_hdr       = in_msg[MSG_WIDTH-1];
    assign hdr_id       = in_msg[MSG_WIDTH-2 -: ID_WIDTH];
    assign hdr_len      = in_msg[MSG_LENGTH_WIDTH-1:0];
    assign hdr_too_long = hdr_len > MAX_LEN;
    assign last_word    = remaining == MSG_LENGTH_WIDTH'(1);

    // Header decode is identical in every state; only the error term differs.
    always_comb begin
        hdr_next = IDLE;
        if (hdr_len == '0)
            hdr_next = IDLE;
        else if (hdr_too_long || hdr_id != MY_ID)
            hdr_next = SKIP;
        else
            hdr_next = WRITE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            reg_we    <= 1'b0;
            reg_addr  <= '0;
            reg_data  <= '0;
            busy      <= 1'b0;
            error     <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            error  <= 1'b0;
            if (in_msg_nd) begin
                if (is_hdr) begin
                    error     <= (state != IDLE) || hdr_too_long;
                    remaining <= hdr_len;
                    state     <= hdr_next;
                    busy      <= hdr_next != IDLE;
                end else begin
                    unique case (state)
                        WRITE: begin
                            reg_we    <= 1'b1;
                            reg_addr  <= in_msg[MSG_WIDTH-2 -: ADDR_WIDTH];
                            reg_data  <= in_msg[DATA_WIDTH-1:0];
                            remaining <= remaining - 1'b1;
                            if (last_word) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                        SKIP: begin
                            remaining <= remaining - 1'b1;
                            if (last_word) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                        default: begin
                            error <= 1'b1;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule
